// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised synchronous FIFO with occupancy, thresholds and error flags
// Optional build macro: SFIFO_STICKY_ERR_EN (overflow/underflow hold until rst instead of pulsing).
module sync_fifo_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             full_w, empty_w;
  logic             rd_acc, wr_acc;
  logic             ovf_evt, unf_evt;

  // Status flags are pure decodes of the occupancy register.
  always_comb begin
    full_w       = (count_q == CNT_FULL);
    empty_w      = (count_q == '0);
    almost_full  = (count_q >= AF_CNT);
    almost_empty = (count_q <= AE_CNT);
  end

  // Accept logic: a full FIFO still takes a write when a read frees a slot in the same cycle;
  // an empty FIFO never forwards the incoming word straight to the read side.
  always_comb begin
    rd_acc  = en & rd & ~empty_w;
    wr_acc  = en & wr & (~full_w | rd_acc);
    ovf_evt = en & wr & ~wr_acc;
    unf_evt = en & rd & empty_w;
  end

  // Next-state for pointers, occupancy, read data and error flags.
  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = rd_acc;

    if (wr_acc) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rptr_d = rptr_q + PTR_ONE;
      dout_d = mem_q[rptr_q];
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

`ifdef SFIFO_STICKY_ERR_EN
    overflow_d  = overflow_q | ovf_evt;
    underflow_d = underflow_q | unf_evt;
`else
    overflow_d  = ovf_evt;
    underflow_d = unf_evt;
`endif
  end

  // Control state register; reset wins over enable and discards any request in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage array: written on accepted writes only, never cleared.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wptr_q] <= din;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign count      = count_q;
  assign full       = full_w;
  assign empty      = empty_w;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param with a queue-based reference model
module tb_sync_fifo_param;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

`ifdef SFIFO_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic             wr  = 1'b0;
  logic             rd  = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [CW-1:0]    count;
  logic             full, empty, almost_full, almost_empty, overflow, underflow;

  int tests = 0;
  int fails = 0;

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .din(din), .rd(rd),
    .dout(dout), .dout_valid(dout_valid), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: contents as a queue, outputs derived from the documented rules.
  logic [WIDTH-1:0] mq [$];
  logic [WIDTH-1:0] m_dout = '0;
  bit               m_dv = 0, m_ovf = 0, m_unf = 0, m_ok = 0;

  always @(posedge clk) begin
    bit rd_ok, wr_ok, ovf_ev, unf_ev;
    if (rst) begin
      mq.delete();
      m_dout = '0; m_dv = 0; m_ovf = 0; m_unf = 0; m_ok = 1;
    end else begin
      rd_ok  = en && rd && (mq.size() > 0);
      wr_ok  = en && wr && ((mq.size() < DEPTH) || rd_ok);
      ovf_ev = en && wr && !wr_ok;
      unf_ev = en && rd && (mq.size() == 0);
      if (rd_ok) m_dout = mq.pop_front();
      m_dv = rd_ok;
      if (wr_ok) mq.push_back(din);
      m_ovf = STICKY ? (m_ovf || ovf_ev) : ovf_ev;
      m_unf = STICKY ? (m_unf || unf_ev) : unf_ev;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_count",   64'(count), 64'(mq.size()));
      chk("m_dout",    64'(dout), 64'(m_dout));
      chk("m_dvalid",  64'(dout_valid), 64'(m_dv));
      chk("m_full",    64'(full), 64'(mq.size() == DEPTH));
      chk("m_empty",   64'(empty), 64'(mq.size() == 0));
      chk("m_afull",   64'(almost_full), 64'(mq.size() >= AF));
      chk("m_aempty",  64'(almost_empty), 64'(mq.size() <= AE));
      chk("m_ovf",     64'(overflow), 64'(m_ovf));
      chk("m_unf",     64'(underflow), 64'(m_unf));
    end
  end

  task automatic step(input logic r, input logic e, input logic w, input logic rr,
                      input logic [WIDTH-1:0] d);
    rst = r; en = e; wr = w; rd = rr; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] drain_exp [8];
    drain_exp = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'hAA};

    // Reset for two cycles
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_aempty", 64'(almost_empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);

    // Fill 0..7
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 1, 0, WIDTH'(i));
      chk("fill_count", 64'(count), 64'(i + 1));
      chk("fill_empty", 64'(empty), 64'd0);
      if (i == 4) chk("fill_af5", 64'(almost_full), 64'd0);
      if (i == 5) chk("fill_af6", 64'(almost_full), 64'd1);
      if (i == 6) chk("fill_full7", 64'(full), 64'd0);
    end
    chk("fill_full", 64'(full), 64'd1);

    // Write while full, no read: rejected
    step(0, 1, 1, 0, 32'h55);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(count), 64'd8);

    // Full with simultaneous rd/wr: oldest out, 0xAA in
    step(0, 1, 1, 1, 32'hAA);
    chk("simf_count", 64'(count), 64'd8);
    chk("simf_dout", 64'(dout), 64'h0);
    chk("simf_dv", 64'(dout_valid), 64'd1);
    chk("ovf_after", 64'(overflow), 64'(STICKY));

    // Drain
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 1, '0);
      chk("drain_dout", 64'(dout), 64'(drain_exp[i]));
      chk("drain_dv", 64'(dout_valid), 64'd1);
      if (i == 5) chk("drain_ae2", 64'(almost_empty), 64'd1);
      if (i == 4) chk("drain_ae3", 64'(almost_empty), 64'd0);
    end
    chk("drain_empty", 64'(empty), 64'd1);
    step(0, 1, 0, 0, '0);
    chk("dv_pulse", 64'(dout_valid), 64'd0);
    chk("dout_hold", 64'(dout), 64'hAA);

    // Empty with simultaneous rd/wr: write only, underflow
    step(0, 1, 1, 1, 32'h33);
    chk("sime_count", 64'(count), 64'd1);
    chk("sime_unf", 64'(underflow), 64'd1);
    chk("sime_dv", 64'(dout_valid), 64'd0);
    step(0, 1, 0, 1, '0);
    chk("sime_read", 64'(dout), 64'h33);
    chk("unf_after", 64'(underflow), 64'(STICKY));

    // Enable low: nothing moves
    step(0, 1, 1, 0, 32'h77);
    step(0, 0, 1, 1, 32'h99);
    chk("en0_count", 64'(count), 64'd1);
    chk("en0_dout", 64'(dout), 64'h33);
    chk("en0_dv", 64'(dout_valid), 64'd0);
    step(0, 1, 0, 1, '0);
    chk("en0_next", 64'(dout), 64'h77);

    // Reset at count 5 with requests pending
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, WIDTH'(32'h200 + i));
    chk("pre_rst", 64'(count), 64'd5);
    step(1, 1, 1, 1, 32'hDEAD);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_empty", 64'(empty), 64'd1);
    chk("mid_rst_unf", 64'(underflow), 64'd0);
    step(0, 1, 0, 1, '0);
    chk("post_rst_unf", 64'(underflow), 64'd1);

    // Wrap-around at count 3
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, WIDTH'(32'h100 + i));
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, 1, WIDTH'(32'h103 + i));
      chk("wrap_dout", 64'(dout), 64'(32'h100 + i));
      chk("wrap_count", 64'(count), 64'd3);
    end
    step(0, 1, 0, 0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
